// File: rtl/kong_motion_engine.sv
// kong_motion_engine: per-frame fixed-point motion for one climbing/jumping
// character. Collisions and keys are accumulated across a frame and consumed
// on startOfFrame; all outputs update in the cycle after the strobe.
// Optional build macro: KONG_FLY_CHEAT_EN adds the cheat_fly input and FLY state.
module kong_motion_engine #(
  parameter int COORD_W     = 11,
  parameter int FRAC_BITS   = 6,
  parameter int DEFAULT_X   = 60,
  parameter int DEFAULT_Y   = 10,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 600,
  parameter int Y_DEATH     = 480,
  parameter int WALK_SPEED  = 80,
  parameter int CLIMB_SPEED = 80,
  parameter int JUMP_SPEED  = 240,
  parameter int GRAVITY     = 2,
  parameter int MAX_FALL    = 230,
  parameter int MAX_JUMPS   = 2
) (
  input  logic                               clk,
  input  logic                               resetN,
  input  logic                               startOfFrame,
  input  logic                               collision_rope,
  input  logic                               collision_platform,
  input  logic [3:0]                         HitEdgeCode,
  input  logic                               ask_right,
  input  logic                               ask_left,
  input  logic                               ask_up,
  input  logic                               ask_down,
  input  logic                               ask_jump,
`ifdef KONG_FLY_CHEAT_EN
  input  logic                               cheat_fly,
`endif
  output logic signed [COORD_W-1:0]          topLeftX,
  output logic signed [COORD_W-1:0]          topLeftY,
  output logic [2:0]                         state,
  output logic                               facing_right,
  output logic [$clog2(MAX_JUMPS+1)-1:0]     jumps_left,
  output logic                               respawned
);

  localparam int IW = COORD_W + FRAC_BITS + 2;
  localparam int JW = $clog2(MAX_JUMPS + 1);

  typedef logic signed [IW-1:0] fx_t;

  localparam fx_t DEF_X_F    = IW'(DEFAULT_X * (2 ** FRAC_BITS));
  localparam fx_t DEF_Y_F    = IW'(DEFAULT_Y * (2 ** FRAC_BITS));
  localparam fx_t X_MIN_F    = IW'(X_MIN * (2 ** FRAC_BITS));
  localparam fx_t X_MAX_F    = IW'(X_MAX * (2 ** FRAC_BITS));
  localparam fx_t X_MIN_P    = IW'(X_MIN);
  localparam fx_t X_MAX_P    = IW'(X_MAX);
  localparam fx_t Y_DEATH_P  = IW'(Y_DEATH);
  localparam fx_t WALK_F     = IW'(WALK_SPEED);
  localparam fx_t CLIMB_F    = IW'(CLIMB_SPEED);
  localparam fx_t JUMP_F     = IW'(JUMP_SPEED);
  localparam fx_t GRAVITY_F  = IW'(GRAVITY);
  localparam fx_t MAX_FALL_F = IW'(MAX_FALL);
  localparam logic [JW-1:0] JUMPS_FULL = JW'(MAX_JUMPS);
  localparam logic [JW-1:0] JUMP_ONE   = JW'(1);

  typedef enum logic [2:0] {
    ST_STAND         = 3'd0,
    ST_CLIMB         = 3'd1,
    ST_AIR           = 3'd2,
    ST_AIR_IN_PLAT   = 3'd3,
    ST_AIR_FROM_ROPE = 3'd4,
    ST_FLY           = 3'd5
  } state_t;

  // Frame accumulators
  logic       acc_rope_q, acc_plat_q;
  logic [3:0] rope_mask_q, plat_mask_q;
  logic       acc_right_q, acc_left_q, acc_up_q, acc_down_q, acc_jump_q;

  // Motion state
  state_t        state_q, state_d;
  fx_t           pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  fx_t           spd_x_q, spd_x_d, spd_y_q, spd_y_d;
  logic          facing_q, facing_d;
  logic [JW-1:0] jumps_q, jumps_d;
  logic          prev_jump_q, prev_jump_d;
  logic          respawn_q, respawn_d;

  // Decode helpers
  logic move_r, move_l, move_u, move_d, jump_edge;
  logic land, grab, fly_now;
  fx_t  grav_sum, grav_y, nx_pix, ny_pix;

  logic unused_mask_bits;
  assign unused_mask_bits = ^{rope_mask_q[2], rope_mask_q[0], plat_mask_q[3:1]};

  assign move_r    = acc_right_q & ~acc_left_q & ~acc_jump_q;
  assign move_l    = acc_left_q & ~acc_right_q & ~acc_jump_q;
  assign move_u    = acc_up_q & ~acc_down_q & ~acc_jump_q;
  assign move_d    = acc_down_q & ~acc_up_q & ~acc_jump_q;
  assign jump_edge = acc_jump_q & ~prev_jump_q;

  assign grav_sum = spd_y_q + GRAVITY_F;
  assign grav_y   = (grav_sum > MAX_FALL_F) ? MAX_FALL_F : grav_sum;

  // Landing is ignored while rising through a platform; grabbing is ignored right after leaving a rope
  assign land = acc_plat_q & plat_mask_q[0] & (state_q != ST_AIR_IN_PLAT);
  assign grab = acc_rope_q & (state_q != ST_AIR_FROM_ROPE);

  // Sticky per-frame collision/key capture; cleared (and strobe-cycle inputs dropped) on startOfFrame
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc_rope_q  <= 1'b0;
      acc_plat_q  <= 1'b0;
      rope_mask_q <= '0;
      plat_mask_q <= '0;
      acc_right_q <= 1'b0;
      acc_left_q  <= 1'b0;
      acc_up_q    <= 1'b0;
      acc_down_q  <= 1'b0;
      acc_jump_q  <= 1'b0;
    end else if (startOfFrame) begin
      acc_rope_q  <= 1'b0;
      acc_plat_q  <= 1'b0;
      rope_mask_q <= '0;
      plat_mask_q <= '0;
      acc_right_q <= 1'b0;
      acc_left_q  <= 1'b0;
      acc_up_q    <= 1'b0;
      acc_down_q  <= 1'b0;
      acc_jump_q  <= 1'b0;
    end else begin
      acc_rope_q  <= acc_rope_q | collision_rope;
      acc_plat_q  <= acc_plat_q | collision_platform;
      rope_mask_q <= collision_rope ? (rope_mask_q | HitEdgeCode) : rope_mask_q;
      plat_mask_q <= collision_platform ? (plat_mask_q | HitEdgeCode) : plat_mask_q;
      acc_right_q <= acc_right_q | ask_right;
      acc_left_q  <= acc_left_q | ask_left;
      acc_up_q    <= acc_up_q | ask_up;
      acc_down_q  <= acc_down_q | ask_down;
      acc_jump_q  <= acc_jump_q | ask_jump;
    end
  end

  // Motion state register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_AIR;
      pos_x_q     <= DEF_X_F;
      pos_y_q     <= DEF_Y_F;
      spd_x_q     <= '0;
      spd_y_q     <= '0;
      facing_q    <= 1'b1;
      jumps_q     <= '0;
      prev_jump_q <= 1'b0;
      respawn_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      spd_x_q     <= spd_x_d;
      spd_y_q     <= spd_y_d;
      facing_q    <= facing_d;
      jumps_q     <= jumps_d;
      prev_jump_q <= prev_jump_d;
      respawn_q   <= respawn_d;
    end
  end

  // Per-frame update: state transition, then X clamp, then fall-off respawn
  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    spd_x_d     = spd_x_q;
    spd_y_d     = spd_y_q;
    facing_d    = facing_q;
    jumps_d     = jumps_q;
    prev_jump_d = prev_jump_q;
    respawn_d   = 1'b0;
    fly_now     = 1'b0;
    nx_pix      = '0;
    ny_pix      = '0;
    if (startOfFrame) begin
      prev_jump_d = acc_jump_q;
      // Position advances by the speed of the previous frame
      pos_x_d = pos_x_q + spd_x_q;
      pos_y_d = pos_y_q + spd_y_q;
      case (state_q)
        ST_STAND: begin
          spd_x_d = '0;
          spd_y_d = '0;
          if (!acc_plat_q) begin
            state_d = ST_AIR_IN_PLAT;
          end else if (jump_edge && (jumps_q != '0)) begin
            state_d = ST_AIR_IN_PLAT;
            spd_y_d = -JUMP_F;
            spd_x_d = facing_q ? WALK_F : -WALK_F;
            jumps_d = jumps_q - JUMP_ONE;
          end else if (move_r) begin
            facing_d = 1'b1;
            spd_x_d  = WALK_F;
          end else if (move_l) begin
            facing_d = 1'b0;
            spd_x_d  = -WALK_F;
          end
        end
        ST_CLIMB: begin
          spd_x_d = '0;
          spd_y_d = '0;
          if (!acc_rope_q) begin
            state_d = ST_AIR_FROM_ROPE;
          end else if (jump_edge) begin
            // Jump off the rope away from the side it was grabbed on
            state_d  = ST_AIR_FROM_ROPE;
            facing_d = ~facing_q;
            spd_x_d  = facing_q ? -WALK_F : WALK_F;
            spd_y_d  = -JUMP_F;
            if (jumps_q != '0) jumps_d = jumps_q - JUMP_ONE;
          end else if (move_u) begin
            spd_y_d = -CLIMB_F;
          end else if (move_d) begin
            spd_y_d = CLIMB_F;
          end
        end
        ST_AIR, ST_AIR_IN_PLAT, ST_AIR_FROM_ROPE: begin
          spd_y_d = grav_y;
          if (land) begin
            state_d = ST_STAND;
            pos_x_d = pos_x_q;
            pos_y_d = pos_y_q;
            spd_x_d = '0;
            spd_y_d = '0;
            jumps_d = JUMPS_FULL;
          end else if (grab) begin
            state_d = ST_CLIMB;
            pos_x_d = pos_x_q;
            pos_y_d = pos_y_q;
            spd_x_d = '0;
            spd_y_d = '0;
            jumps_d = JUMPS_FULL;
            if (rope_mask_q[3])      facing_d = 1'b0;
            else if (rope_mask_q[1]) facing_d = 1'b1;
          end else begin
            if (state_q == ST_AIR && acc_plat_q)                  state_d = ST_AIR_IN_PLAT;
            if (state_q == ST_AIR_IN_PLAT && !acc_plat_q)         state_d = ST_AIR;
            if (state_q == ST_AIR_FROM_ROPE && !acc_rope_q)       state_d = ST_AIR;
            if (jump_edge && (jumps_q != '0)) begin
              spd_y_d = -JUMP_F;
              jumps_d = jumps_q - JUMP_ONE;
            end
          end
        end
        default: begin
          // FLY exit (or any unreachable code): drop into free fall from rest
          state_d = ST_AIR;
          spd_x_d = '0;
          spd_y_d = '0;
        end
      endcase
`ifdef KONG_FLY_CHEAT_EN
      if (cheat_fly) begin
        fly_now  = 1'b1;
        state_d  = ST_FLY;
        pos_x_d  = pos_x_q + spd_x_q;
        pos_y_d  = pos_y_q + spd_y_q;
        facing_d = facing_q;
        jumps_d  = jumps_q;
        spd_x_d  = move_r ? WALK_F : (move_l ? -WALK_F : '0);
        spd_y_d  = move_u ? -WALK_F : (move_d ? WALK_F : '0);
      end
`endif
      nx_pix = pos_x_d >>> FRAC_BITS;
      if (nx_pix < X_MIN_P) begin
        pos_x_d = X_MIN_F;
        spd_x_d = '0;
      end else if (nx_pix > X_MAX_P) begin
        pos_x_d = X_MAX_F;
        spd_x_d = '0;
      end
      ny_pix = pos_y_d >>> FRAC_BITS;
      if (!fly_now && (ny_pix >= Y_DEATH_P)) begin
        state_d   = ST_AIR;
        pos_x_d   = DEF_X_F;
        pos_y_d   = DEF_Y_F;
        spd_x_d   = '0;
        spd_y_d   = '0;
        jumps_d   = '0;
        respawn_d = 1'b1;
      end
    end
  end

  assign topLeftX     = COORD_W'(pos_x_q >>> FRAC_BITS);
  assign topLeftY     = COORD_W'(pos_y_q >>> FRAC_BITS);
  assign state        = state_q;
  assign facing_right = facing_q;
  assign jumps_left   = jumps_q;
  assign respawned    = respawn_q;

endmodule

// File: tb/tb_kong_motion_engine.sv
// Directed bench for kong_motion_engine; expected values hand-computed
// from the fixed-point motion rules (64 units per pixel).
module tb_kong_motion_engine;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic startOfFrame = 1'b0;
  logic collision_rope = 1'b0;
  logic collision_platform = 1'b0;
  logic [3:0] HitEdgeCode = '0;
  logic ask_right = 1'b0, ask_left = 1'b0, ask_up = 1'b0, ask_down = 1'b0, ask_jump = 1'b0;
`ifdef KONG_FLY_CHEAT_EN
  logic cheat_fly = 1'b0;
`endif
  logic signed [10:0] topLeftX, topLeftY;
  logic [2:0] state;
  logic facing_right;
  logic [1:0] jumps_left;
  logic respawned;

  int checks = 0;
  int failures = 0;

  localparam logic [4:0] K_N = 5'b00000;
  localparam logic [4:0] K_R = 5'b10000;
  localparam logic [4:0] K_L = 5'b01000;
  localparam logic [4:0] K_U = 5'b00100;
  localparam logic [4:0] K_J = 5'b00001;

  kong_motion_engine dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .collision_rope(collision_rope), .collision_platform(collision_platform),
    .HitEdgeCode(HitEdgeCode),
    .ask_right(ask_right), .ask_left(ask_left), .ask_up(ask_up),
    .ask_down(ask_down), .ask_jump(ask_jump),
`ifdef KONG_FLY_CHEAT_EN
    .cheat_fly(cheat_fly),
`endif
    .topLeftX(topLeftX), .topLeftY(topLeftY), .state(state),
    .facing_right(facing_right), .jumps_left(jumps_left), .respawned(respawned)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  // Platform pixel in one cycle, rope pixel in the next, keys held for both, then the strobe
  task automatic do_frame(input logic plat, input logic [3:0] pe, input logic rope,
                          input logic [3:0] re, input logic [4:0] keys);
    @(negedge clk);
    collision_platform = plat; collision_rope = 1'b0; HitEdgeCode = plat ? pe : 4'b0000;
    {ask_right, ask_left, ask_up, ask_down, ask_jump} = keys;
    @(negedge clk);
    collision_platform = 1'b0; collision_rope = rope; HitEdgeCode = rope ? re : 4'b0000;
    @(negedge clk);
    collision_rope = 1'b0; HitEdgeCode = '0;
    {ask_right, ask_left, ask_up, ask_down, ask_jump} = K_N;
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (topLeftX !== 11'sd60) begin failures++; $display("FAIL reset_x got=%0d exp=60", topLeftX); end
    checks++; if (topLeftY !== 11'sd10) begin failures++; $display("FAIL reset_y got=%0d exp=10", topLeftY); end
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL reset_state got=%0d exp=2", state); end
    checks++; if (facing_right !== 1'b1) begin failures++; $display("FAIL reset_facing got=%0b exp=1", facing_right); end
    checks++; if (jumps_left !== 2'd0) begin failures++; $display("FAIL reset_jumps got=%0d exp=0", jumps_left); end
    checks++; if (respawned !== 1'b0) begin failures++; $display("FAIL reset_respawned got=%0b exp=0", respawned); end
  endtask

  // Internal Y 640, 642, 646 -> pixel 10 each frame
  task automatic test_fall();
    for (int f = 1; f <= 3; f++) begin
      do_frame(1'b0, 4'b0000, 1'b0, 4'b0000, K_N);
      checks++; if (topLeftY !== 11'sd10) begin failures++; $display("FAIL fall_y%0d got=%0d exp=10", f, topLeftY); end
      checks++; if (state !== 3'd2) begin failures++; $display("FAIL fall_state%0d got=%0d exp=2", f, state); end
    end
  endtask

  task automatic test_land();
    do_frame(1'b1, 4'b0001, 1'b0, 4'b0000, K_N);
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL land_state got=%0d exp=0", state); end
    checks++; if (jumps_left !== 2'd2) begin failures++; $display("FAIL land_jumps got=%0d exp=2", jumps_left); end
    checks++; if (topLeftY !== 11'sd10) begin failures++; $display("FAIL land_y got=%0d exp=10", topLeftY); end
    do_frame(1'b1, 4'b0001, 1'b0, 4'b0000, K_N);
    checks++; if (topLeftY !== 11'sd10) begin failures++; $display("FAIL land_frozen_y got=%0d exp=10", topLeftY); end
    checks++; if (topLeftX !== 11'sd60) begin failures++; $display("FAIL land_frozen_x got=%0d exp=60", topLeftX); end
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL land_hold_state got=%0d exp=0", state); end
  endtask

  // From STAND at internal (3840,646): jump, air jump, then a refused third jump
  task automatic test_jump();
    do_frame(1'b1, 4'b0001, 1'b0, 4'b0000, K_J);
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL jump1_state got=%0d exp=3", state); end
    checks++; if (jumps_left !== 2'd1) begin failures++; $display("FAIL jump1_jumps got=%0d exp=1", jumps_left); end
    do_frame(1'b0, 4'b0000, 1'b0, 4'b0000, K_N);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL jump2_state got=%0d exp=2", state); end
    checks++; if (topLeftY !== 11'sd6) begin failures++; $display("FAIL jump2_y got=%0d exp=6", topLeftY); end
    checks++; if (topLeftX !== 11'sd61) begin failures++; $display("FAIL jump2_x got=%0d exp=61", topLeftX); end
    do_frame(1'b0, 4'b0000, 1'b0, 4'b0000, K_J);
    checks++; if (jumps_left !== 2'd0) begin failures++; $display("FAIL jump3_jumps got=%0d exp=0", jumps_left); end
    checks++; if (topLeftY !== 11'sd2) begin failures++; $display("FAIL jump3_y got=%0d exp=2", topLeftY); end
    do_frame(1'b0, 4'b0000, 1'b0, 4'b0000, K_N);
    checks++; if (topLeftY !== -11'sd2) begin failures++; $display("FAIL jump4_y got=%0d exp=-2", topLeftY); end
    checks++; if (topLeftX !== 11'sd63) begin failures++; $display("FAIL jump4_x got=%0d exp=63", topLeftX); end
    do_frame(1'b0, 4'b0000, 1'b0, 4'b0000, K_J);
    checks++; if (jumps_left !== 2'd0) begin failures++; $display("FAIL jump5_jumps got=%0d exp=0", jumps_left); end
    checks++; if (topLeftY !== -11'sd5) begin failures++; $display("FAIL jump5_y got=%0d exp=-5", topLeftY); end
    checks++; if (topLeftX !== 11'sd65) begin failures++; $display("FAIL jump5_x got=%0d exp=65", topLeftX); end
  endtask

  task automatic test_cancel();
    do_reset();
    do_frame(1'b1, 4'b0001, 1'b0, 4'b0000, K_N);
    for (int f = 1; f <= 2; f++) begin
      do_frame(1'b1, 4'b0001, 1'b0, 4'b0000, K_R | K_L);
      checks++; if (topLeftX !== 11'sd60) begin failures++; $display("FAIL cancel_x%0d got=%0d exp=60", f, topLeftX); end
    end
    checks++; if (facing_right !== 1'b1) begin failures++; $display("FAIL cancel_facing got=%0b exp=1", facing_right); end
  endtask

  task automatic test_rope();
    do_reset();
    do_frame(1'b0, 4'b0000, 1'b1, 4'b1000, K_N);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL rope_grab_state got=%0d exp=1", state); end
    checks++; if (facing_right !== 1'b0) begin failures++; $display("FAIL rope_grab_facing got=%0b exp=0", facing_right); end
    checks++; if (jumps_left !== 2'd2) begin failures++; $display("FAIL rope_grab_jumps got=%0d exp=2", jumps_left); end
    do_frame(1'b0, 4'b0000, 1'b1, 4'b1000, K_U);
    checks++; if (topLeftY !== 11'sd10) begin failures++; $display("FAIL rope_up1_y got=%0d exp=10", topLeftY); end
    do_frame(1'b0, 4'b0000, 1'b1, 4'b1000, K_N);
    checks++; if (topLeftY !== 11'sd8) begin failures++; $display("FAIL rope_up2_y got=%0d exp=8", topLeftY); end
    do_frame(1'b0, 4'b0000, 1'b1, 4'b1000, K_J);
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL rope_jump_state got=%0d exp=4", state); end
    checks++; if (facing_right !== 1'b1) begin failures++; $display("FAIL rope_jump_facing got=%0b exp=1", facing_right); end
    do_frame(1'b0, 4'b0000, 1'b1, 4'b1000, K_N);
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL rope_leave_state got=%0d exp=4", state); end
    checks++; if (topLeftX !== 11'sd61) begin failures++; $display("FAIL rope_leave_x got=%0d exp=61", topLeftX); end
    checks++; if (topLeftY !== 11'sd5) begin failures++; $display("FAIL rope_leave_y got=%0d exp=5", topLeftY); end
    do_frame(1'b0, 4'b0000, 1'b0, 4'b0000, K_N);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL rope_free_state got=%0d exp=2", state); end
    checks++; if (topLeftY !== 11'sd1) begin failures++; $display("FAIL rope_free_y got=%0d exp=1", topLeftY); end
  endtask

  // Internal X = 3840 + 80*(f-1): pixel 598 at f=432, 600 at f=433, clamp from f=434
  task automatic test_clamp_right();
    do_reset();
    do_frame(1'b1, 4'b0001, 1'b0, 4'b0000, K_N);
    for (int f = 1; f <= 440; f++) begin
      do_frame(1'b1, 4'b0001, 1'b0, 4'b0000, K_R);
      if (f == 432) begin
        checks++; if (topLeftX !== 11'sd598) begin failures++; $display("FAIL clampr_x%0d got=%0d exp=598", f, topLeftX); end
      end
      if (f >= 433) begin
        checks++; if (topLeftX !== 11'sd600) begin failures++; $display("FAIL clampr_x%0d got=%0d exp=600", f, topLeftX); end
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL clampr_state%0d got=%0d exp=0", f, state); end
      end
    end
  endtask

  // Internal X = 3840 - 80*(f-1): pixel 1 at f=48, 0 at f=49, clamp from f=50
  task automatic test_clamp_left();
    do_reset();
    do_frame(1'b1, 4'b0001, 1'b0, 4'b0000, K_N);
    for (int f = 1; f <= 52; f++) begin
      do_frame(1'b1, 4'b0001, 1'b0, 4'b0000, K_L);
      if (f == 48) begin
        checks++; if (topLeftX !== 11'sd1) begin failures++; $display("FAIL clampl_x%0d got=%0d exp=1", f, topLeftX); end
      end
      if (f >= 49) begin
        checks++; if (topLeftX !== 11'sd0) begin failures++; $display("FAIL clampl_x%0d got=%0d exp=0", f, topLeftX); end
      end
    end
    checks++; if (facing_right !== 1'b0) begin failures++; $display("FAIL clampl_facing got=%0b exp=0", facing_right); end
  endtask

  // Free fall from reset: Y=477 after frame 188, crosses 480 on frame 189
  task automatic test_respawn();
    do_reset();
    for (int f = 1; f <= 189; f++) begin
      do_frame(1'b0, 4'b0000, 1'b0, 4'b0000, K_N);
      checks++; if (respawned !== (f == 189)) begin failures++; $display("FAIL respawn_pulse_f%0d got=%0b exp=%0b", f, respawned, f == 189); end
      if (f == 188) begin
        checks++; if (topLeftY !== 11'sd477) begin failures++; $display("FAIL respawn_pre_y got=%0d exp=477", topLeftY); end
      end
    end
    checks++; if (topLeftX !== 11'sd60) begin failures++; $display("FAIL respawn_x got=%0d exp=60", topLeftX); end
    checks++; if (topLeftY !== 11'sd10) begin failures++; $display("FAIL respawn_y got=%0d exp=10", topLeftY); end
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL respawn_state got=%0d exp=2", state); end
    checks++; if (jumps_left !== 2'd0) begin failures++; $display("FAIL respawn_jumps got=%0d exp=0", jumps_left); end
    @(negedge clk);
    checks++; if (respawned !== 1'b0) begin failures++; $display("FAIL respawn_one_cycle got=%0b exp=0", respawned); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    do_frame(1'b1, 4'b0001, 1'b0, 4'b0000, K_N);
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL mid_pre_state got=%0d exp=0", state); end
    @(negedge clk);
    collision_platform = 1'b1; HitEdgeCode = 4'b0001;
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL mid_async_state got=%0d exp=2", state); end
    @(negedge clk);
    collision_platform = 1'b0; HitEdgeCode = '0; resetN = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL mid_after_state got=%0d exp=2", state); end
    checks++; if (topLeftY !== 11'sd10) begin failures++; $display("FAIL mid_after_y got=%0d exp=10", topLeftY); end
    // Collision present only in the strobe cycle is dropped
    @(negedge clk);
    startOfFrame = 1'b1; collision_platform = 1'b1; HitEdgeCode = 4'b0001;
    @(negedge clk);
    startOfFrame = 1'b0; collision_platform = 1'b0; HitEdgeCode = '0;
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL sof_drop_state got=%0d exp=2", state); end
    do_frame(1'b0, 4'b0000, 1'b0, 4'b0000, K_N);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL sof_drop_next_state got=%0d exp=2", state); end
  endtask

  initial begin
    test_reset();
    test_fall();
    test_land();
    test_jump();
    test_cancel();
    test_rope();
    test_clamp_right();
    test_clamp_left();
    test_respawn();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
